// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 hex keypad scanner.
// Codes are row*4 + col; row/column strobes on the keypad are active-low.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } kp_state_t;

    localparam int KP_ROWS = 4;
    localparam int KP_COLS = 4;

    function automatic logic [3:0] kp_code(input logic [1:0] row, input logic [1:0] col);
        return {row, col};
    endfunction

    // Lowest-numbered asserted row wins when several rows are low together.
    function automatic logic [1:0] kp_row_sel(input logic [KP_ROWS-1:0] rows_n);
        logic [1:0] sel;
        if (!rows_n[0]) begin
            sel = 2'd0;
        end else if (!rows_n[1]) begin
            sel = 2'd1;
        end else if (!rows_n[2]) begin
            sel = 2'd2;
        end else begin
            sel = 2'd3;
        end
        return sel;
    endfunction

    function automatic logic [KP_COLS-1:0] kp_col_strobe(input logic [1:0] col);
        return ~(4'b0001 << col);
    endfunction

endpackage

// File: rtl/scan_tick.sv
// Free-running prescaler producing a one-cycle enable every DIV clocks.
// Used instead of a divided clock so all downstream logic stays on the board clock.
module scan_tick #(
    parameter int DIV = 100000
) (
    input  logic clk,
    input  logic clr_n,
    output logic o_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] r_cnt;
    logic          r_tick;

    // Prescaler count and registered wrap pulse.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            if (r_cnt == LAST) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + ONE;
            end
            r_tick <= (r_cnt == LAST);
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: column strobing, debounced press/release FSM, one key per press
// delivered over valid/ack, and a 32-bit hex entry word shifted per accepted key.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                clk,
    input  logic                clr_n,
    input  logic [KP_ROWS-1:0]  key_row,
    output logic [KP_COLS-1:0]  key_col,
    output logic                key_valid,
    output logic [3:0]          key_code,
    input  logic                key_ack,
    output logic                key_overrun,
    output logic [31:0]         entry
);

    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic               w_tick;
    logic [KP_ROWS-1:0] r_row_meta;
    logic [KP_ROWS-1:0] r_row_sync;

    kp_state_t          r_state;
    kp_state_t          w_state_nxt;
    logic [1:0]         r_col;
    logic [1:0]         w_col_nxt;
    logic [1:0]         r_row_lat;
    logic [1:0]         w_row_lat_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [KP_COLS-1:0] r_key_col;

    logic               w_pressed;
    logic [1:0]         w_row_sel;
    logic               w_lat_pressed;
    logic [3:0]         w_code;
    logic               w_emit;

    logic               r_key_valid;
    logic [3:0]         r_key_code;
    logic               r_overrun;
    logic [31:0]        r_entry;

    scan_tick #(
        .DIV (SCAN_DIV)
    ) u_scan_tick (
        .clk    (clk),
        .clr_n  (clr_n),
        .o_tick (w_tick)
    );

    // Two-flop synchroniser for the asynchronous row inputs; idle rows read high.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_row_meta <= 4'hF;
            r_row_sync <= 4'hF;
        end else begin
            r_row_meta <= key_row;
            r_row_sync <= r_row_meta;
        end
    end

    assign w_pressed     = (r_row_sync != 4'hF);
    assign w_row_sel     = kp_row_sel(r_row_sync);
    assign w_lat_pressed = ~r_row_sync[r_row_lat];
    assign w_code        = kp_code(w_row_sel, r_col);
    assign w_cnt_inc     = (r_cnt == CNT_MAX) ? r_cnt : (r_cnt + CNT_ONE);

    // Next-state logic; nothing moves except on a scan tick.
    always_comb begin
        w_state_nxt   = r_state;
        w_col_nxt     = r_col;
        w_row_lat_nxt = r_row_lat;
        w_cnt_nxt     = r_cnt;
        w_emit        = 1'b0;
        if (w_tick) begin
            case (r_state)
                SCAN: begin
                    if (w_pressed) begin
                        w_row_lat_nxt = w_row_sel;
                        w_cnt_nxt     = CNT_ONE;
                        if (DEBOUNCE_SCANS == 1) begin
                            w_emit      = 1'b1;
                            w_state_nxt = HELD;
                        end else begin
                            w_state_nxt = DEBOUNCE;
                        end
                    end else begin
                        w_col_nxt = r_col + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (w_pressed && (w_row_sel == r_row_lat)) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == CNT_MAX) begin
                            w_emit      = 1'b1;
                            w_state_nxt = HELD;
                        end else begin
                            w_state_nxt = DEBOUNCE;
                        end
                    end else begin
                        w_state_nxt = SCAN;
                        w_col_nxt   = r_col + 2'd1;
                        w_cnt_nxt   = '0;
                    end
                end
                HELD: begin
                    if (w_lat_pressed) begin
                        w_state_nxt = HELD;
                    end else if (DEBOUNCE_SCANS == 1) begin
                        w_state_nxt = SCAN;
                        w_col_nxt   = r_col + 2'd1;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = RELEASE;
                        w_cnt_nxt   = CNT_ONE;
                    end
                end
                RELEASE: begin
                    if (!w_lat_pressed) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == CNT_MAX) begin
                            w_state_nxt = SCAN;
                            w_col_nxt   = r_col + 2'd1;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_state_nxt = RELEASE;
                        end
                    end else begin
                        // Release glitch: return to HELD without a second emit.
                        w_state_nxt = HELD;
                    end
                end
                default: begin
                    w_state_nxt = SCAN;
                    w_cnt_nxt   = '0;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // FSM state, column index, latched row and debounce counter.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state   <= SCAN;
            r_col     <= 2'd0;
            r_row_lat <= 2'd0;
            r_cnt     <= '0;
            r_key_col <= 4'b1110;
        end else begin
            r_state   <= w_state_nxt;
            r_col     <= w_col_nxt;
            r_row_lat <= w_row_lat_nxt;
            r_cnt     <= w_cnt_nxt;
            r_key_col <= kp_col_strobe(w_col_nxt);
        end
    end

    // Consumer handshake, overrun flag and entry shift register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_key_valid <= 1'b0;
            r_key_code  <= 4'd0;
            r_overrun   <= 1'b0;
            r_entry     <= 32'd0;
        end else begin
            if (w_emit && (!r_key_valid || key_ack)) begin
                r_key_valid <= 1'b1;
                r_key_code  <= w_code;
                r_entry     <= {r_entry[27:0], w_code};
            end else if (r_key_valid && key_ack) begin
                r_key_valid <= 1'b0;
            end else begin
                r_key_valid <= r_key_valid;
            end

            if (w_emit && r_key_valid && !key_ack) begin
                r_overrun <= 1'b1;
            end else if (r_key_valid && key_ack) begin
                r_overrun <= 1'b0;
            end else begin
                r_overrun <= r_overrun;
            end
        end
    end

    assign key_col     = r_key_col;
    assign key_valid   = r_key_valid;
    assign key_code    = r_key_code;
    assign key_overrun = r_overrun;
    assign entry       = r_entry;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a keypad model that drives rows from the column strobes.
module tb_keypad_scan;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic [3:0]  key_row;
    logic [3:0]  key_col;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_ack = 1'b0;
    logic        key_overrun;
    logic [31:0] entry;

    logic [15:0] keys = 16'd0;
    int          n_vec = 0;
    int          n_err = 0;
    int          rises = 0;
    logic        prev_valid = 1'b0;

    typedef struct {
        int          key;
        logic [3:0]  exp_code;
        logic [31:0] exp_entry;
    } kp_vec_t;

    kp_vec_t vec [5];

    keypad_scan #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .key_row     (key_row),
        .key_col     (key_col),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_ack     (key_ack),
        .key_overrun (key_overrun),
        .entry       (entry)
    );

    always #5 clk = ~clk;

    // Key (r,c) closed pulls row r low while column c is strobed.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            key_row[r] = ~|(keys[r*4 +: 4] & ~key_col);
        end
    end

    always @(negedge clk) begin
        prev_valid <= key_valid;
        if (key_valid && !prev_valid) rises <= rises + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n * 4) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr_n   = 1'b0;
        keys    = 16'd0;
        key_ack = 1'b0;
        repeat (3) @(negedge clk);
        clr_n = 1'b1;
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        key_ack = 1'b1;
        @(negedge clk);
        key_ack = 1'b0;
    endtask

    task automatic press(input int k);
        keys    = 16'd0;
        keys[k] = 1'b1;
    endtask

    initial begin
        int  r0;
        bit  found;

        vec[0] = '{9,  4'd9,  32'h0000_0009};
        vec[1] = '{7,  4'd7,  32'h0000_0097};
        vec[2] = '{15, 4'd15, 32'h0000_097F};
        vec[3] = '{0,  4'd0,  32'h0000_97F0};
        vec[4] = '{10, 4'd10, 32'h0009_7F0A};

        // Reset values while clr_n is held low
        @(negedge clk);
        repeat (2) @(negedge clk);
        check("rst_col",     32'(key_col),     32'h0000_000E);
        check("rst_valid",   32'(key_valid),   32'd0);
        check("rst_code",    32'(key_code),    32'd0);
        check("rst_overrun", 32'(key_overrun), 32'd0);
        check("rst_entry",   entry,            32'd0);
        clr_n = 1'b1;

        // Table of clean presses, each acked after release
        for (int i = 0; i < 5; i++) begin
            r0 = rises;
            press(vec[i].key);
            ticks(12);
            check("tbl_valid",   32'(key_valid),   32'd1);
            check("tbl_code",    32'(key_code),    32'(vec[i].exp_code));
            check("tbl_entry",   entry,            vec[i].exp_entry);
            check("tbl_overrun", 32'(key_overrun), 32'd0);
            check("tbl_emits",   32'(rises - r0),  32'd1);
            keys = 16'd0;
            ticks(6);
            ack_pulse();
            check("tbl_ack", 32'(key_valid), 32'd0);
        end

        // Asynchronous reset while debouncing key 9
        do_reset();
        r0 = rises;
        press(9);
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (key_col == 4'b1101) found = 1'b1;
        end
        check("mid_col_seen", 32'(found), 32'd1);
        repeat (6) @(negedge clk);
        #2 clr_n = 1'b0;
        #1;
        check("mid_col",     32'(key_col),     32'h0000_000E);
        check("mid_valid",   32'(key_valid),   32'd0);
        check("mid_code",    32'(key_code),    32'd0);
        check("mid_overrun", 32'(key_overrun), 32'd0);
        check("mid_entry",   entry,            32'd0);
        check("mid_noemit",  32'(rises - r0),  32'd0);
        keys = 16'd0;
        @(negedge clk);
        clr_n = 1'b1;

        // Bouncing key 7: no emit while toggling, exactly one after it settles
        do_reset();
        r0 = rises;
        for (int i = 0; i < 5; i++) begin
            keys = (i % 2 == 0) ? 16'h0080 : 16'h0000;
            ticks(1);
        end
        check("bnc_noemit", 32'(rises - r0), 32'd0);
        keys = 16'h0080;
        ticks(12);
        check("bnc_emits", 32'(rises - r0), 32'd1);
        check("bnc_code",  32'(key_code),   32'd7);
        check("bnc_entry", entry,           32'h0000_0007);
        keys = 16'd0;
        ticks(6);

        // Overrun: key 1 left unacked, key 2 dropped
        do_reset();
        press(1);
        ticks(12);
        keys = 16'd0;
        ticks(6);
        press(2);
        ticks(12);
        keys = 16'd0;
        ticks(6);
        check("ovr_valid", 32'(key_valid),   32'd1);
        check("ovr_code",  32'(key_code),    32'd1);
        check("ovr_flag",  32'(key_overrun), 32'd1);
        check("ovr_entry", entry,            32'h0000_0001);
        ack_pulse();
        check("ovr_ack_valid", 32'(key_valid),   32'd0);
        check("ovr_ack_flag",  32'(key_overrun), 32'd0);

        // Ack in the same cycle as the emit of key 5
        do_reset();
        press(4);
        ticks(12);
        keys = 16'd0;
        ticks(6);
        r0 = rises;
        press(5);
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (dut.w_emit) found = 1'b1;
        end
        check("same_emit_seen", 32'(found), 32'd1);
        key_ack = 1'b1;
        @(negedge clk);
        key_ack = 1'b0;
        check("same_valid",   32'(key_valid),   32'd1);
        check("same_code",    32'(key_code),    32'd5);
        check("same_entry",   entry,            32'h0000_0045);
        check("same_overrun", 32'(key_overrun), 32'd0);
        check("same_rises",   32'(rises - r0),  32'd0);
        keys = 16'd0;
        ticks(6);

        // Two rows in column 2 (keys 2 and 14), then a glitch during release
        do_reset();
        r0 = rises;
        keys = 16'h4004;
        ticks(12);
        check("two_valid", 32'(key_valid),  32'd1);
        check("two_code",  32'(key_code),   32'd2);
        check("two_emits", 32'(rises - r0), 32'd1);
        ack_pulse();
        check("two_ack", 32'(key_valid), 32'd0);
        keys = 16'd0;
        repeat (8) @(negedge clk);
        keys = 16'h4004;
        repeat (4) @(negedge clk);
        keys = 16'd0;
        ticks(10);
        check("glitch_emits", 32'(rises - r0), 32'd1);
        check("glitch_valid", 32'(key_valid),  32'd0);
        check("glitch_entry", entry,           32'h0000_0002);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
